// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry, pixel/address types and fill FSM states
package fb_pkg;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int ADDR_W = 17;
  localparam int COLOR_W = 12;
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef enum logic [1:0] {IDLE, FILL, DONE} fb_state_t;
  function automatic fb_addr_t row_addr(input logic [7:0] y, input logic [8:0] x);
    return (fb_addr_t'(y) << 8) + (fb_addr_t'(y) << 6) + fb_addr_t'(x);
  endfunction
endpackage

// File: rtl/fb_rect_clip.sv
// fb_rect_clip: trims a rectangle's width/height to the visible framebuffer area
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [8:0] x0_i,
  input  logic [7:0] y0_i,
  input  logic [8:0] w_i,
  input  logic [7:0] h_i,
  output logic [8:0] w_o,
  output logic [7:0] h_o
);
  logic [8:0] w_room;
  logic [7:0] h_room;
  assign w_room = 9'(FB_W) - x0_i;
  assign h_room = 8'(FB_H) - y0_i;
  assign w_o = (x0_i >= 9'(FB_W)) ? '0 : (w_i < w_room ? w_i : w_room);
  assign h_o = (y0_i >= 8'(FB_H)) ? '0 : (h_i < h_room ? h_i : h_room);
endmodule

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: row-major rectangle fill into the 320x240 framebuffer; clipping enabled by FB_RECT_CLIP_EN
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8:0]         cmd_x0,
  input  logic [7:0]         cmd_y0,
  input  logic [8:0]         cmd_w,
  input  logic [7:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               busy,
  output logic               done,
  output logic               fb_we_o,
  output logic [ADDR_W-1:0]  fb_addr_o,
  output logic [COLOR_W-1:0] fb_wdata_o
);
  fb_state_t state_q;
  color_t color_q, wdata_q;
  fb_addr_t row_base_q, addr_q, base_d;
  logic [8:0] w_q, xcnt_q, w_d;
  logic [7:0] h_q, ycnt_q, h_d;
  logic cmd_ready_q, busy_q, done_q, we_q, last_x, last_y;
`ifdef FB_RECT_CLIP_EN
  fb_rect_clip u_clip (
    .x0_i(cmd_x0),
    .y0_i(cmd_y0),
    .w_i (cmd_w),
    .h_i (cmd_h),
    .w_o (w_d),
    .h_o (h_d)
  );
`else
  assign w_d = cmd_w;
  assign h_d = cmd_h;
`endif
  assign base_d = row_addr(cmd_y0, cmd_x0);
  assign last_x = xcnt_q == w_q - 9'd1;
  assign last_y = ycnt_q == h_q - 8'd1;
  assign cmd_ready = cmd_ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fb_we_o = we_q;
  assign fb_addr_o = addr_q;
  assign fb_wdata_o = wdata_q;
  // Fill FSM; the write on the bus always belongs to (xcnt_q, ycnt_q), so the first pixel is issued at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      color_q <= '0;
      row_base_q <= '0;
      w_q <= '0;
      h_q <= '0;
      xcnt_q <= '0;
      ycnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid && cmd_ready_q) begin
          color_q <= cmd_color;
          w_q <= w_d;
          h_q <= h_d;
          xcnt_q <= '0;
          ycnt_q <= '0;
          row_base_q <= base_d;
          cmd_ready_q <= 1'b0;
          busy_q <= 1'b1;
          if (w_d == '0 || h_d == '0) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end else begin
            state_q <= FILL;
            we_q <= 1'b1;
            addr_q <= base_d;
            wdata_q <= cmd_color;
          end
        end
        FILL: if (last_x && last_y) begin
          we_q <= 1'b0;
          done_q <= 1'b1;
          state_q <= DONE;
        end else if (last_x) begin
          xcnt_q <= '0;
          ycnt_q <= ycnt_q + 8'd1;
          row_base_q <= row_base_q + fb_addr_t'(FB_W);
          addr_q <= row_base_q + fb_addr_t'(FB_W);
        end else begin
          xcnt_q <= xcnt_q + 9'd1;
          addr_q <= addr_q + fb_addr_t'(1);
        end
        DONE: begin
          state_q <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: scoreboard bench with a pixel-level reference model of the rectangle fill
module tb_fb_rect_fill;
  import fb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic [8:0] cmd_x0 = '0, cmd_w = '0;
  logic [7:0] cmd_y0 = '0, cmd_h = '0;
  logic [COLOR_W-1:0] cmd_color = '0;
  logic cmd_ready, busy, done, fb_we_o;
  logic [ADDR_W-1:0] fb_addr_o;
  logic [COLOR_W-1:0] fb_wdata_o;
  fb_rect_fill dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .busy      (busy),
    .done      (done),
    .fb_we_o   (fb_we_o),
    .fb_addr_o (fb_addr_o),
    .fb_wdata_o(fb_wdata_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit is_done;
    int addr;
    int data;
    int cyc;
  } ev_t;
  ev_t exp_q[$];
  ev_t e;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit prev_done = 1'b0;
  always @(posedge clk) cyc++;
  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask
  // Expected trace: w_eff*h_eff writes in row-major order on consecutive cycles, then one done cycle
  task automatic expect_cmd(int x, int y, int w, int h, int c, int n);
    int we_ = w;
    int he = h;
`ifdef FB_RECT_CLIP_EN
    we_ = (x >= FB_W) ? 0 : ((w < FB_W - x) ? w : FB_W - x);
    he = (y >= FB_H) ? 0 : ((h < FB_H - y) ? h : FB_H - y);
`endif
    for (int r = 0; r < he; r++)
      for (int k = 0; k < we_; k++)
        exp_q.push_back('{1'b0, (y + r) * FB_W + x + k, c, n + 1 + r * we_ + k});
    exp_q.push_back('{1'b1, 0, 0, n + 1 + we_ * he});
  endtask
  task automatic send(int x, int y, int w, int h, int c);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_x0 = 9'(x);
    cmd_y0 = 8'(y);
    cmd_w = 9'(w);
    cmd_h = 8'(h);
    cmd_color = COLOR_W'(c);
    while (!cmd_ready && n < 200000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout cmd_ready=%0d want=1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      expect_cmd(x, y, w, h, c, cyc);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_events", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  // Monitor: every write or done cycle must match the head of the expected trace
  always @(negedge clk) begin
    if (fb_we_o || done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event we=%0d done=%0d addr=%0d want=none (cycle %0d)", fb_we_o, done, fb_addr_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("event_is_done", int'(done), int'(e.is_done));
        chk("event_cycle", cyc, e.cyc);
        if (!e.is_done) begin
          chk("write_addr", int'(fb_addr_o), e.addr);
          chk("write_data", int'(fb_wdata_o), e.data);
        end
      end
    end
    if (prev_done && !rst) chk("ready_after_done", int'(cmd_ready), 1);
    if (fb_we_o || done) chk("busy_not_ready", int'({busy, cmd_ready}), 2);
    prev_done = done;
  end
  initial begin
    int x, y, w, h;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_we", int'(fb_we_o), 0);
    chk("reset_addr", int'(fb_addr_o), 0);
    chk("reset_wdata", int'(fb_wdata_o), 0);
    rst = 1'b0;
    send(0, 0, 1, 1, 'hABC);
    drain();
    send(10, 5, 3, 2, 'hF00);
    drain();
    send(20, 7, 0, 4, 'h123);
    drain();
    send(100, 50, 5, 3, 'h1A2);
    send(0, 239, 4, 1, 'h3B4);
    send(319, 0, 1, 2, 'h5C6);
    drain();
    send(0, 0, 320, 240, 'h0F0);
    drain();
    send(40, 40, 50, 4, 'h555);
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_fill_we", int'(fb_we_o), 0);
    chk("rst_mid_fill_ready", int'(cmd_ready), 1);
    chk("rst_mid_fill_busy", int'(busy), 0);
    #1 rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_done", int'(done), 0);
    end
`ifdef FB_RECT_CLIP_EN
    send(318, 238, 5, 5, 'h0AA);
    send(400, 0, 10, 10, 'h777);
    drain();
`endif
    for (int i = 0; i < 30; i++) begin
`ifdef FB_RECT_CLIP_EN
      x = $urandom_range(0, 340);
      y = $urandom_range(0, 250);
      w = $urandom_range(0, 16);
      h = $urandom_range(0, 8);
`else
      x = $urandom_range(0, FB_W - 1);
      y = $urandom_range(0, FB_H - 1);
      w = $urandom_range(0, (FB_W - x < 16) ? FB_W - x : 16);
      h = $urandom_range(0, (FB_H - y < 8) ? FB_H - y : 8);
`endif
      send(x, y, w, h, int'($urandom_range(0, 4095)));
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
